// File: rtl/spi_slave_pkg.sv
// Shared state encoding, command codes and frame-width helper for the SPI slave.
package spi_slave_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA_RX,
    READ_DATA_TX,
    WAIT_SS
  } state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  function automatic int frame_w(input int cmd_w, input int data_w);
    return cmd_w + data_w;
  endfunction

endpackage

// File: rtl/spi_shift_ctr.sv
// MSB-first shift register with a bit counter; done flags the final bit of a W-bit word.
module spi_shift_ctr #(
  parameter int W     = 8,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift,
  input  logic         sin,
  output logic [W-1:0] q,
  output logic         done
);

  logic [CNT_W-1:0] cnt;

  assign done = (cnt == CNT_W'(W - 1));

  // counter wraps to zero on the last shift so it never overflows
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= '0;
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      q   <= load_val;
      cnt <= '0;
    end else if (shift) begin
      q   <= {q[W-2:0], sin};
      cnt <= done ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_slave_burst.sv
// SPI slave front-end: deserialises {cmd,data} frames, serialises RAM read words
// on MISO (optionally as a burst), and flags frames cut short by SS_n.
module spi_slave_burst
  import spi_slave_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int CMD_W    = 2,
  parameter int BURST_EN = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    SS_n,
  input  logic                    MOSI,
  output logic                    MISO,
  output logic [CMD_W+DATA_W-1:0] rx_data,
  output logic                    rx_valid,
  input  logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_valid,
  output logic                    frame_err,
  output logic                    rd_addr_pending
);

  localparam int FRAME_W = frame_w(CMD_W, DATA_W);

  state_e state, state_nxt;

  logic rx_shift, rx_clr, rx_done;
  logic tx_load, tx_abort, tx_shift, tx_done;
  logic [DATA_W-1:0] tx_q, tx_load_val;
  logic [DATA_W-2:0] unused_tx_low;
  logic tx_busy, tx_busy_nxt, word_seen, word_seen_nxt;
  logic rx_valid_nxt, frame_err_nxt, pend_nxt;

  spi_shift_ctr #(.W(FRAME_W)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .clr      (rx_clr),
    .load     (1'b0),
    .load_val ('0),
    .shift    (rx_shift),
    .sin      (MOSI),
    .q        (rx_data),
    .done     (rx_done)
  );

  // zeros shift in behind the word, so the MSB flop doubles as the registered MISO
  assign tx_load_val = tx_abort ? '0 : tx_data;

  spi_shift_ctr #(.W(DATA_W)) u_tx (
    .clk      (clk),
    .rst      (rst),
    .clr      (1'b0),
    .load     (tx_load),
    .load_val (tx_load_val),
    .shift    (tx_shift),
    .sin      (1'b0),
    .q        (tx_q),
    .done     (tx_done)
  );

  assign MISO          = tx_q[DATA_W-1];
  assign unused_tx_low = tx_q[DATA_W-2:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      tx_busy         <= 1'b0;
      word_seen       <= 1'b0;
      rx_valid        <= 1'b0;
      frame_err       <= 1'b0;
      rd_addr_pending <= 1'b0;
    end else begin
      state           <= state_nxt;
      tx_busy         <= tx_busy_nxt;
      word_seen       <= word_seen_nxt;
      rx_valid        <= rx_valid_nxt;
      frame_err       <= frame_err_nxt;
      rd_addr_pending <= pend_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    rx_shift      = 1'b0;
    rx_clr        = 1'b0;
    tx_load       = 1'b0;
    tx_abort      = 1'b0;
    tx_shift      = 1'b0;
    tx_busy_nxt   = tx_busy;
    word_seen_nxt = word_seen;
    rx_valid_nxt  = 1'b0;
    frame_err_nxt = 1'b0;
    pend_nxt      = rd_addr_pending;
    unique case (state)
      IDLE: begin
        word_seen_nxt = 1'b0;
        if (!SS_n) state_nxt = CHK_CMD;
      end
      CHK_CMD: begin
        if (SS_n) begin
          state_nxt     = IDLE;
          frame_err_nxt = 1'b1;
        end else if (!MOSI) begin
          state_nxt = WRITE;
        end else begin
          state_nxt = rd_addr_pending ? READ_DATA_RX : READ_ADD;
        end
      end
      WRITE, READ_ADD, READ_DATA_RX: begin
        if (SS_n) begin
          state_nxt     = IDLE;
          frame_err_nxt = 1'b1;
          rx_clr        = 1'b1;
        end else begin
          rx_shift = 1'b1;
          if (rx_done) begin
            rx_valid_nxt = 1'b1;
            if (state == READ_DATA_RX) begin
              state_nxt = READ_DATA_TX;
            end else begin
              state_nxt = WAIT_SS;
              if (state == READ_ADD) pend_nxt = 1'b1;
            end
          end
        end
      end
      READ_DATA_TX: begin
        if (tx_busy) begin
          if (!tx_done && SS_n) begin
            tx_load       = 1'b1;
            tx_abort      = 1'b1;
            tx_busy_nxt   = 1'b0;
            state_nxt     = IDLE;
            frame_err_nxt = 1'b1;
          end else begin
            tx_shift = 1'b1;
            if (tx_done) begin
              tx_busy_nxt   = 1'b0;
              word_seen_nxt = 1'b1;
              if (SS_n || BURST_EN == 0) state_nxt = WAIT_SS;
            end
          end
        end else if (SS_n) begin
          // deselect between burst words is a clean end; before any word it is an abort
          state_nxt     = IDLE;
          frame_err_nxt = !word_seen;
        end else if (tx_valid) begin
          tx_load     = 1'b1;
          tx_busy_nxt = 1'b1;
          pend_nxt    = 1'b0;
        end
      end
      WAIT_SS: begin
        if (SS_n) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
